// File: rtl/sobel_frame_controller.sv
// Sequencing control for a 3x3 Sobel pipeline: it accepts pixels, then pads the tail of the frame with zero shifts, and tags each result beat with its row and column.
// Each beat appears KERNEL_LAT+1 cycles after its shift. A stall on in_valid holds back shifting and does nothing else.
module sobel_frame_controller #(
  parameter int WIDTH      = 100,
  parameter int HEIGHT     = 100,
  parameter int KERNEL_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      shift_en,
  output logic                      pad_sel,
  output logic                      busy,
  output logic                      out_valid,
  output logic                      out_border,
  output logic                      out_sol,
  output logic                      out_eol,
  output logic                      out_last,
  output logic [$clog2(HEIGHT)-1:0] out_row,
  output logic [$clog2(WIDTH)-1:0]  out_col,
  output logic                      frame_done
);

  localparam int RW   = $clog2(HEIGHT);
  localparam int CW   = $clog2(WIDTH);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int KW   = $clog2(NPIX + WIDTH + 2);
  localparam int DW   = $clog2(KERNEL_LAT + 1) + 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DRAIN} state_t;

  typedef struct packed {
    logic          vld;
    logic          border;
    logic          sol;
    logic          eol;
    logic          last;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } beat_t;

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [DW-1:0] r_drain;
  beat_t         r_dl [KERNEL_LAT+1];

  logic  w_accept;
  logic  w_flush;
  logic  w_emit;
  beat_t w_beat;

  assign w_accept = (r_state == S_FILL) || (r_state == S_RUN);
  assign w_flush  = (r_state == S_FLUSH);
  assign in_ready = w_accept;
  assign shift_en = w_flush | (w_accept & in_valid);
  assign pad_sel  = w_flush;
  assign busy     = (r_state != S_IDLE);
  // The first WIDTH+1 shifts only fill the window, so they produce no center.
  assign w_emit   = shift_en && (r_k >= KW'(WIDTH + 1));

  always_comb begin
    w_beat = '0;
    if (w_emit) begin
      w_beat.vld    = 1'b1;
      w_beat.row    = r_row;
      w_beat.col    = r_col;
      w_beat.sol    = (r_col == '0);
      w_beat.eol    = (r_col == CW'(WIDTH - 1));
      w_beat.border = (r_row == '0) || (r_row == RW'(HEIGHT - 1)) || w_beat.sol || w_beat.eol;
      w_beat.last   = (r_row == RW'(HEIGHT - 1)) && w_beat.eol;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FILL;
            r_k     <= '0;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        S_FILL, S_RUN: begin
          if (in_valid) begin
            r_k <= r_k + KW'(1);
            if (r_k == KW'(NPIX - 1))
              r_state <= S_FLUSH;
            else if (r_k == KW'(WIDTH))
              r_state <= S_RUN;
          end
        end
        S_FLUSH: begin
          r_k <= r_k + KW'(1);
          if (r_k == KW'(NPIX + WIDTH)) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end
        end
        S_DRAIN: begin
          if (r_drain == DW'(KERNEL_LAT))
            r_state <= S_IDLE;
          else
            r_drain <= r_drain + DW'(1);
        end
        default: r_state <= S_IDLE;
      endcase

      // The row holds at its last value so it cannot run past the frame.
      if (w_emit) begin
        if (r_col == CW'(WIDTH - 1)) begin
          r_col <= '0;
          if (r_row != RW'(HEIGHT - 1))
            r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= KERNEL_LAT; i++)
        r_dl[i] <= '0;
    end else begin
      r_dl[0] <= w_beat;
      for (int i = 1; i <= KERNEL_LAT; i++)
        r_dl[i] <= r_dl[i-1];
    end
  end

  assign out_valid  = r_dl[KERNEL_LAT].vld;
  assign out_border = r_dl[KERNEL_LAT].border;
  assign out_sol    = r_dl[KERNEL_LAT].sol;
  assign out_eol    = r_dl[KERNEL_LAT].eol;
  assign out_last   = r_dl[KERNEL_LAT].last;
  assign out_row    = r_dl[KERNEL_LAT].row;
  assign out_col    = r_dl[KERNEL_LAT].col;
  assign frame_done = r_dl[KERNEL_LAT].vld & r_dl[KERNEL_LAT].last;

endmodule

// File: tb/tb_sobel_frame_controller.sv
// Scoreboard bench for sobel_frame_controller with WIDTH=4, HEIGHT=3 and KERNEL_LAT=1.
module tb_sobel_frame_controller;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int KL   = 1;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       shift_en;
  logic       pad_sel;
  logic       busy;
  logic       out_valid;
  logic       out_border;
  logic       out_sol;
  logic       out_eol;
  logic       out_last;
  logic [1:0] out_row;
  logic [1:0] out_col;
  logic       frame_done;

  sobel_frame_controller #(.WIDTH(W), .HEIGHT(H), .KERNEL_LAT(KL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .shift_en(shift_en), .pad_sel(pad_sel), .busy(busy),
    .out_valid(out_valid), .out_border(out_border), .out_sol(out_sol),
    .out_eol(out_eol), .out_last(out_last), .out_row(out_row),
    .out_col(out_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int idx;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_beat(input int c, input int idx);
    exp_t e;
    e.cyc = c + KL + 1;
    e.idx = idx;
    sb.push_back(e);
  endtask

  // A frame starts in cycle 0. The task can add a second start, an in_valid gap and a one-cycle reset.
  task automatic run_scen(input string nm, input int ncyc, input int st_lo, input int st_hi,
                          input int start2, input int rst_cyc, input int ef0, input int ef1,
                          input int ed0, input int ed1, input int nbeats);
    int   mph, acc, fl, dr, beats, nfr, ndn, i, r, cl;
    int   rf[2];
    int   rd[2];
    logic e_sh, e_sol, e_eol, e_brd, e_last;
    exp_t b;
    sb.delete();
    mph = 0; acc = 0; fl = 0; dr = 0; beats = 0; nfr = 0; ndn = 0;
    rf[0] = -1; rf[1] = -1; rd[0] = -1; rd[1] = -1;
    for (int c = 0; c < ncyc; c++) begin
      start    = (c == 0) || (c == start2);
      in_valid = !(c >= st_lo && c <= st_hi);
      rst_n    = (c != rst_cyc);
      @(negedge clk);
      if (!rst_n) begin
        chk({nm, " rst outs"}, 32'({out_valid, busy, in_ready, shift_en, pad_sel, frame_done,
                                   out_border, out_sol, out_eol, out_last, out_row, out_col}), 0);
        sb.delete();
        mph = 0;
      end else begin
        e_sh = (mph == 1) ? in_valid : (mph == 2);
        chk({nm, " in_ready"}, 32'(in_ready), 32'(mph == 1));
        chk({nm, " shift_en"}, 32'(shift_en), 32'(e_sh));
        chk({nm, " pad_sel"},  32'(pad_sel),  32'(mph == 2));
        chk({nm, " busy"},     32'(busy),     32'(mph != 0));
        if (sb.size() > 0 && sb[0].cyc == c) begin
          b = sb.pop_front();
          i = b.idx; r = i / W; cl = i % W;
          e_sol = (cl == 0); e_eol = (cl == W - 1);
          e_brd = (r == 0) || (r == H - 1) || e_sol || e_eol;
          e_last = (r == H - 1) && e_eol;
          chk({nm, " out_valid"},  32'(out_valid), 1);
          chk({nm, " out_row"},    32'(out_row), 32'(r));
          chk({nm, " out_col"},    32'(out_col), 32'(cl));
          chk({nm, " out_border"}, 32'(out_border), 32'(e_brd));
          chk({nm, " out_sol"},    32'(out_sol), 32'(e_sol));
          chk({nm, " out_eol"},    32'(out_eol), 32'(e_eol));
          chk({nm, " out_last"},   32'(out_last), 32'(e_last));
          chk({nm, " frame_done"}, 32'(frame_done), 32'(e_last));
          if (out_valid) beats++;
          if (i == 0 && nfr < 2) rf[nfr++] = c;
          if (e_last && frame_done && ndn < 2) rd[ndn++] = c;
        end else begin
          chk({nm, " idle out_valid"}, 32'(out_valid), 0);
          chk({nm, " idle sideband"}, 32'({out_border, out_sol, out_eol, out_last, out_row, out_col, frame_done}), 0);
          if (out_valid) beats++;
        end
        case (mph)
          0: if (start) begin mph = 1; acc = 0; end
          1: if (in_valid) begin
               if (acc >= W + 1) push_beat(c, acc - (W + 1));
               acc++;
               if (acc == NPIX) begin mph = 2; fl = 0; end
             end
          2: begin
               push_beat(c, NPIX + fl - (W + 1));
               fl++;
               if (fl == W + 1) begin mph = 3; dr = 0; end
             end
          default: begin
               dr++;
               if (dr == KL + 1) mph = 0;
             end
        endcase
      end
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
    chk({nm, " beat count"}, 32'(beats), 32'(nbeats));
    chk({nm, " first beat A"}, 32'(rf[0]), 32'(ef0));
    chk({nm, " first beat B"}, 32'(rf[1]), 32'(ef1));
    chk({nm, " done A"}, 32'(rd[0]), 32'(ed0));
    chk({nm, " done B"}, 32'(rd[1]), 32'(ed1));
    chk({nm, " sb empty"}, 32'(sb.size()), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_scen("basic",   25, -1, -1, -1, -1,  8, -1, 19, -1, 12);
    run_scen("stall",   28,  3,  5, -1, -1, 11, -1, 22, -1, 12);
    run_scen("restart", 25, -1, -1,  5, -1,  8, -1, 19, -1, 12);
    run_scen("reset",   40, -1, -1, 15, 10,  8, 23, 34, -1, 14);
    run_scen("b2b",     44, -1, -1, 20, -1,  8, 28, 19, 39, 24);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
